// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: state_t (IDLE/RUN/DONE), default operand width, bit-counter width helper.
package serial_adder_pkg;

    // Default operand/result width in bits (minimum 2).
    localparam int SA_WIDTH = 8;

    // Bit counter width for the default width.
    localparam int SA_CNT_W = $clog2(SA_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for an arbitrary operand width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/FAD.sv
// One-bit full-adder cell used as the bit slice of the serial adder.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b, cin (inputs), sum, cout (outputs).
module FAD (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: sum/cout = a + b + cin, one bit per clock through a single FAD cell.
// Latency: result visible WIDTH clocks after the accepting edge; accepts spaced WIDTH+2 apart.
// Backpressure: valid/ready on both sides; result held in DONE until out_ready, one op in flight.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with a, b, cin;
//        out_valid/out_ready with sum, cout; busy flags the RUN state.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] rreg;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             fa_sum;
    logic             fa_cout;

    // Single bit slice: LSBs of both operand shifters plus the running carry.
    FAD u_fad (
        .a    (areg[0]),
        .b    (breg[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state only, so no ready->valid or valid->ready paths exist.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            RUN:     busy      = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Datapath. The result register fills from the MSB side, so after WIDTH shifts
    // bit 0 of the sum sits at bit 0. The visible sum/cout only change on the
    // final RUN cycle, which keeps them stable through IDLE and RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            areg  <= '0;
            breg  <= '0;
            rreg  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                areg  <= a;
                breg  <= b;
                carry <= cin;
                cnt   <= '0;
            end
        end else if (state == RUN) begin
            areg  <= areg >> 1;
            breg  <= breg >> 1;
            rreg  <= {fa_sum, rreg[WIDTH-1:1]};
            carry <= fa_cout;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= {fa_sum, rreg[WIDTH-1:1]};
                cout <= fa_cout;
            end
        end
    end

endmodule
